// File: rtl/bfp_stream_normalizer.sv
// bfp_stream_normalizer: collects FP16 elements into blocks and emits them
// as sign plus significand aligned to the block's shared maximum exponent.
module bfp_stream_normalizer #(
    parameter int ELEM_W     = 16,
    parameter int EXP_W      = 5,
    parameter int MAN_W      = 10,
    parameter int BLOCK_SIZE = 4,
    parameter int IDX_W      = $clog2(BLOCK_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [MAN_W:0]    out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last
);
    typedef enum logic {COLLECT, EMIT} state_t;

    localparam logic [EXP_W:0] SAT = (EXP_W+1)'(MAN_W + 1);

    state_t            state;
    logic [ELEM_W-1:0] mem [BLOCK_SIZE];
    logic [IDX_W-1:0]  cnt, k;
    logic [EXP_W-1:0]  run_max, shared_exp;
    logic [IDX_W:0]    len;

    logic [EXP_W-1:0]  in_exp, in_eff, new_max;
    logic              close;
    logic [ELEM_W-1:0] cur;
    logic [EXP_W-1:0]  cur_exp, cur_eff, shift;
    logic [MAN_W:0]    cur_sig, mant;
    logic              is_last;

    always_comb begin
        in_exp  = in_data[ELEM_W-2 -: EXP_W];
        in_eff  = (in_exp == '0) ? EXP_W'(1) : in_exp;
        new_max = (in_eff > run_max) ? in_eff : run_max;
        close   = (cnt == IDX_W'(BLOCK_SIZE - 1)) || in_last;
        cur     = mem[k];
        cur_exp = cur[ELEM_W-2 -: EXP_W];
        cur_eff = (cur_exp == '0) ? EXP_W'(1) : cur_exp;
        cur_sig = {cur_exp != '0, cur[MAN_W-1:0]};
        shift   = shared_exp - cur_eff;
        mant    = ({1'b0, shift} >= SAT) ? '0 : cur_sig >> shift;
        is_last = ({1'b0, k} == len - 1'b1);
    end

    // Handshake flags come straight from the state register; data is gated to zero when idle.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == EMIT);
    assign out_sign  = out_valid & cur[ELEM_W-1];
    assign out_mant  = out_valid ? mant : '0;
    assign out_exp   = out_valid ? shared_exp : '0;
    assign out_index = out_valid ? k : '0;
    assign out_last  = out_valid & is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            cnt        <= '0;
            k          <= '0;
            run_max    <= '0;
            shared_exp <= '0;
            len        <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) mem[i] <= '0;
        end else if (state == COLLECT) begin
            if (in_valid) begin
                mem[cnt] <= in_data;
                if (close) begin
                    len        <= {1'b0, cnt} + 1'b1;
                    shared_exp <= new_max;
                    run_max    <= '0;
                    cnt        <= '0;
                    state      <= EMIT;
                end else begin
                    run_max <= new_max;
                    cnt     <= cnt + 1'b1;
                end
            end
        end else if (out_ready) begin
            if (is_last) begin
                k     <= '0;
                state <= COLLECT;
            end else begin
                k <= k + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bfp_stream_normalizer.sv
// tb_bfp_stream_normalizer: table-driven and randomised blocks checked through
// an expected-output scoreboard, plus latency, backpressure and reset sequences.
module tb_bfp_stream_normalizer;
    typedef struct packed {
        logic [3:0][15:0] d;
        logic [2:0]       n;
        logic [4:0]       e;
        logic [3:0][10:0] m;
        logic [3:0]       s;
    } vec_t;

    typedef struct packed {
        logic        sgn;
        logic [10:0] mant;
        logic [4:0]  exp;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic [15:0] in_data = 0;
    logic        in_ready, out_valid, out_sign, out_last;
    logic [10:0] out_mant;
    logic [4:0]  out_exp;
    logic [1:0]  out_index;

    int   checks = 0, errors = 0;
    exp_t sb[$];
    bit   rand_ready = 0, rand_stall = 0, last_hs = 0;
    vec_t tbl[5];

    bfp_stream_normalizer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sign(out_sign), .out_mant(out_mant),
        .out_exp(out_exp), .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, input int n, input int e,
                                input int m0, m1, m2, m3, input logic [3:0] s);
        mk.d = {d3, d2, d1, d0};
        mk.n = 3'(n);
        mk.e = 5'(e);
        mk.m = {11'(m3), 11'(m2), 11'(m1), 11'(m0)};
        mk.s = s;
    endfunction

    task automatic push_tbl(input vec_t v);
        exp_t x;
        for (int i = 0; i < int'(v.n); i++) begin
            x.sgn = v.s[i]; x.mant = v.m[i]; x.exp = v.e; x.idx = 2'(i); x.last = (i == int'(v.n) - 1);
            sb.push_back(x);
        end
    endtask

    // Reference: shared exponent as the max effective exponent, then truncating division.
    task automatic push_model(input logic [3:0][15:0] d, input int n);
        int mx = 1, e, eff, sig, sh;
        exp_t x;
        for (int i = 0; i < n; i++) begin
            e = int'(d[i][14:10]);
            eff = (e == 0) ? 1 : e;
            if (eff > mx) mx = eff;
        end
        for (int i = 0; i < n; i++) begin
            e = int'(d[i][14:10]);
            eff = (e == 0) ? 1 : e;
            sig = ((e != 0) ? 1024 : 0) + int'(d[i][9:0]);
            sh = mx - eff;
            x.sgn = d[i][15]; x.mant = 11'((sh > 10) ? 0 : sig / (1 << sh));
            x.exp = 5'(mx); x.idx = 2'(i); x.last = (i == n - 1);
            sb.push_back(x);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l, input int gap);
        int n = 0;
        in_valid = 1; in_data = d; in_last = l;
        do begin @(negedge clk); n++; end while (!in_ready && n < 200);
        if (!in_ready) chk("accept_timeout", 32'(n), 0);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
        repeat (gap + (rand_stall ? int'($urandom_range(0, 2)) : 0)) begin @(posedge clk); #1; end
    endtask

    task automatic send_block(input logic [3:0][15:0] d, input int n, input int gap, input bit lf);
        for (int i = 0; i < n; i++) send(d[i], (i == n - 1) && (n < 4 || lf), (i == n - 1) ? 0 : gap);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin @(negedge clk); n++; end
        chk("drain_in_budget", 32'(n < 300), 1);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) if (rst_n) begin
        exp_t e;
        chk("in_ready_vs_out_valid", in_ready, !out_valid);
        if (last_hs) chk("in_ready_after_last", in_ready, 1);
        last_hs = 0;
        if (!out_valid) chk("idle_outputs_zero", {out_sign, out_mant, out_exp, out_index, out_last}, 0);
        else if (out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output index=%0d mant=%0d", out_index, out_mant);
            end else begin
                e = sb.pop_front();
                chk("out_sign", out_sign, e.sgn);
                chk("out_mant", out_mant, e.mant);
                chk("out_exp", out_exp, e.exp);
                chk("out_index", out_index, e.idx);
                chk("out_last", out_last, e.last);
            end
            last_hs = out_last;
        end
    end

    always @(posedge clk) if (rand_ready) begin #1; out_ready = 1'($urandom % 2); end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [3:0][15:0] rd;
        logic [16:0] snap;
        int n;
        tbl[0] = mk(16'h3C00, 16'h4000, 16'h3800, 16'hC400, 4, 17, 256, 512, 128, 1024, 4'b1000);
        tbl[1] = mk(16'h0001, 16'h0400, 16'h0000, 16'h0000, 2, 1, 1, 1024, 0, 0, 4'b0000);
        tbl[2] = mk(16'h7BFF, 16'h0400, 16'h0000, 16'h8000, 4, 30, 2047, 0, 0, 0, 4'b1000);
        tbl[3] = mk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4, 15, 1024, 1024, 1024, 1024, 4'b0000);
        tbl[4] = mk(16'h8200, 16'h0800, 16'h0000, 16'h0000, 2, 2, 256, 1024, 0, 0, 4'b0001);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", {out_sign, out_mant, out_exp, out_index, out_last}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            push_tbl(tbl[i]);
            send_block(tbl[i].d, int'(tbl[i].n), 0, 0);
            @(negedge clk);
            chk("out_valid_after_close", out_valid, 1);
            drain();
        end

        push_tbl(tbl[0]);
        send_block(tbl[0].d, 4, 0, 1);
        drain();

        push_tbl(tbl[0]);
        send_block(tbl[0].d, 4, 2, 0);
        drain();

        out_ready = 0;
        push_tbl(tbl[0]);
        send_block(tbl[0].d, 4, 0, 0);
        in_valid = 1; in_data = 16'h7777; in_last = 1;
        @(negedge clk);
        snap = {out_valid, out_sign, out_mant, out_index, out_last};
        chk("bp_first_valid", snap, {1'b1, 1'b0, 11'd256, 2'd0, 1'b0});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold_stable", {out_valid, out_sign, out_mant, out_index, out_last}, snap);
            chk("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; chk("bp_emit_in_ready", in_ready, !out_valid); end
            while (!(out_valid && out_last) && n < 20);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
        drain();
        push_tbl(tbl[2]);
        send_block(tbl[2].d, 4, 0, 0);
        drain();

        push_tbl(tbl[0]);
        send_block(tbl[0].d, 4, 0, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(out_valid && out_index == 2) && n < 20);
        rst_n = 0;
        #1;
        sb.delete();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", {out_sign, out_mant, out_exp, out_index, out_last}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        push_tbl(tbl[3]);
        send_block(tbl[3].d, 4, 0, 0);
        drain();

        rand_ready = 1; rand_stall = 1;
        for (int b = 0; b < 30; b++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) rd[i] = 16'($urandom);
            if (b % 5 == 0) rd[0] = 16'h0000;
            if (b % 7 == 0) rd[n-1] = {1'b1, 5'd0, 10'($urandom)};
            push_model(rd, n);
            send_block(rd, n, 0, 1'($urandom % 2));
        end
        drain();
        rand_ready = 0; rand_stall = 0;
        #1 out_ready = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bfp_stream_normalizer.md
# bfp_stream_normalizer

Streaming block-floating-point normaliser. It accepts IEEE-style half-precision elements one per cycle over a valid/ready handshake and collects them into blocks of up to BLOCK_SIZE elements. It then emits each element as sign plus aligned significand, together with the block's shared (maximum) exponent. It sits between the FP16 operand feed and the BFP multiply-accumulate datapath, and replaces the fixed four-input combinational normaliser.

## Interface
- ELEM_W, 16, element width; must equal 1+EXP_W+MAN_W
- EXP_W, 5, exponent field width
- MAN_W, 10, stored mantissa width
- BLOCK_SIZE, 4, maximum elements per block (>=2)
- IDX_W, $clog2(BLOCK_SIZE), derived index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input element valid
- in_ready  out  1  input accepted when in_valid & in_ready
- in_data  in  ELEM_W  {sign, exponent, mantissa}
- in_last  in  1  closes the block early with this element
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  element sign
- out_mant  out  MAN_W+1  aligned significand (hidden bit included)
- out_exp  out  EXP_W  shared block exponent
- out_index  out  IDX_W  element position within block
- out_last  out  1  final element of block

## Operation
- Decode per element: sig = {exp!=0, man}; eff_exp = (exp==0) ? 1 : exp. Exponent all-ones (Inf/NaN) gets no special handling and is an ordinary exponent.
- Two states: COLLECT and EMIT. Reset state is COLLECT.
- COLLECT: in_ready=1. Each accepted element is stored at buf[cnt]. The running max is updated as max(run_max, eff_exp), and cnt increments.
- A block closes on the accepted element when cnt==BLOCK_SIZE-1 or in_last=1. On close:
  - len := cnt+1
  - shared_exp := max(run_max, eff_exp of the closing element)
  - run_max and cnt clear; state goes to EMIT
- EMIT: in_ready=0 and out_valid=1.
  - For element k: shift = shared_exp - eff_exp[k]; out_mant = sig[k] >> shift. Truncation only, no rounding. If shift >= MAN_W+1, out_mant=0.
  - out_sign = stored sign, out_exp = shared_exp, out_index = k, out_last = (k==len-1).
  - k advances on out_valid & out_ready.
  - The handshake on out_last returns state to COLLECT and clears k.
- An all-zero or all-subnormal block gives shared_exp = 1.
- Zero elements produce out_mant=0 and keep their sign.

## Timing
- Reset values: state=COLLECT, cnt=0, k=0, run_max=0, shared_exp=0, len=0.
  - Outputs at reset: in_ready=1, out_valid=0, and all out_* data = 0.
- While out_valid=0, out_sign, out_mant, out_exp, out_index and out_last are forced to 0.
- in_ready and out_valid are decoded directly from the state register; there is no combinational path from the inputs to them.
- Latency:
  - Closing element accepted at edge t: out_valid=1 with element 0 from t+1.
  - Last output handshake at edge u: in_ready=1 from u+1.
- Throughput: one element per cycle in each phase. Phases do not overlap (single buffer).
- Backpressure: while out_valid=1 and out_ready=0, all out_* hold stable.
- Stalls on either side do not change the block contents.
- in_last is ignored unless in_valid & in_ready. in_last on a full-count element closes the block normally, with len = BLOCK_SIZE.
- Reset asserted mid-COLLECT or mid-EMIT discards the block; all state returns to reset values immediately.

## Test plan
- **Basic block** (defaults; out_ready=1):
  - Stimulus: inputs 0x3C00, 0x4000, 0x3800, 0xC400.
  - Required: out_exp=17 for all four; out_mant = 256, 512, 128, 1024; signs 0,0,0,1; out_index 0..3; out_last only on index 3.
  - Required: first out_valid the cycle after the fourth accept; in_ready=1 the cycle after the last output.
- **Early close, subnormal**:
  - Stimulus: 0x0001, then 0x0400 with in_last=1.
  - Required: two outputs, out_exp=1, out_mant = 1 then 1024, out_last on the second.
  - Required: the next block then accepts four elements normally.
- **Shift saturation**:
  - Stimulus: 0x7BFF, 0x0400, 0x0000, 0x8000.
  - Required: out_exp=30; out_mant = 2047, 0, 0, 0; sign 1 on the fourth.
- **Backpressure**:
  - Stimulus: basic block with out_ready held 0 for 3 cycles after out_valid rises; in_valid kept high throughout EMIT.
  - Required: element 0 stable for 4 cycles; in_ready=0 through EMIT; no extra input accepted.
- **Input stalls**:
  - Stimulus: in_valid toggling 1,0,0,1,... across a block.
  - Required: same results as the basic block; cnt advances only on handshakes.
- **Reset mid-EMIT**:
  - Stimulus: assert rst_n=0 after output index 1.
  - Required: out_valid=0 and in_ready=1 immediately.
  - Required: a following block (0x3C00 ×4) gives out_exp=15 and out_mant=1024 ×4, with no stale data.
